// File: rtl/mac_sequencer.sv
// ============================================================================
//  mac_sequencer -- command-driven byte-lane MAC over two operand buffers
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mac_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_function_id,
    input  logic [31:0] cmd_inputs_0,
    input  logic [31:0] cmd_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_outputs_0
);

    localparam logic [2:0] c_OP_WR_INPUT  = 3'd0;
    localparam logic [2:0] c_OP_WR_FILTER = 3'd1;
    localparam logic [2:0] c_OP_RUN       = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         acc_q, acc_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                mode_q, mode_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [31:0]         in_mem_q  [DEPTH];
    logic [31:0]         flt_mem_q [DEPTH];

    logic                w_wr_input;
    logic                w_wr_filter;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W:0]     w_count;
    logic [31:0]         w_in_word;
    logic [31:0]         w_flt_word;
    logic signed [16:0]  w_prod [4];
    logic signed [18:0]  w_sum4;
    logic [31:0]         w_word_sum;
    logic                w_unused_fid;

    assign w_unused_fid = &{1'b0, cmd_function_id[9:4]};
    assign w_waddr      = cmd_inputs_0[ADDR_W-1:0];
    assign w_count      = (cmd_inputs_0 > 32'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                      : cmd_inputs_0[ADDR_W:0];
    assign w_in_word    = in_mem_q[idx_q];
    assign w_flt_word   = flt_mem_q[idx_q];

    // Adding 128 to a signed byte is the same as flipping its sign bit and
    // reading it as unsigned, giving a 0..255 operand.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic signed [8:0] w_in_off;
        assign w_in_off  = {1'b0, ~w_in_word[8*b+7], w_in_word[8*b +: 7]};
        assign w_prod[b] = w_in_off * $signed(w_flt_word[8*b +: 8]);
    end

    assign w_sum4 = {{2{w_prod[0][16]}}, w_prod[0]} + {{2{w_prod[1][16]}}, w_prod[1]}
                  + {{2{w_prod[2][16]}}, w_prod[2]} + {{2{w_prod[3][16]}}, w_prod[3]};
    assign w_word_sum = mode_q ? {{15{w_prod[0][16]}}, w_prod[0]}
                               : {{13{w_sum4[18]}}, w_sum4};

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_outputs_0 = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        w_wr_input  = 1'b0;
        w_wr_filter = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_function_id[2:0])
                        c_OP_WR_INPUT: begin
                            w_wr_input = 1'b1;
                            rsp_data_d = 32'd0;
                            state_d    = S_RESP;
                        end
                        c_OP_WR_FILTER: begin
                            w_wr_filter = 1'b1;
                            rsp_data_d  = 32'd0;
                            state_d     = S_RESP;
                        end
                        c_OP_RUN: begin
                            acc_d  = cmd_inputs_1;
                            idx_d  = '0;
                            rem_d  = w_count;
                            mode_d = cmd_function_id[3];
                            if (w_count == '0) begin
                                rsp_data_d = cmd_inputs_1;
                                state_d    = S_RESP;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        default: begin
                            rsp_data_d = acc_q;
                            state_d    = S_RESP;
                        end
                    endcase
                end
            end
            S_RUN: begin
                acc_d = acc_q + w_word_sum;
                idx_d = idx_q + ADDR_W'(1);
                rem_d = rem_q - (ADDR_W+1)'(1);
                if (rem_q == (ADDR_W+1)'(1)) begin
                    rsp_data_d = acc_d;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                // The valid flag rises one cycle after entering RESP.
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= 32'd0;
            idx_q       <= '0;
            rem_q       <= '0;
            mode_q      <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_input) begin
            in_mem_q[w_waddr] <= cmd_inputs_1;
        end
        if (w_wr_filter) begin
            flt_mem_q[w_waddr] <= cmd_inputs_1;
        end
    end

endmodule

`default_nettype wire

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of 32-bit words in each operand buffer (power of two, 2..256).
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(DEPTH), giving the buffer address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-008 cmd_function_id  input  10  [2:0] opcode; [3] single-lane mode for RUN; [9:4] ignored.
REQ-009 cmd_inputs_0  input  32  address (writes) or word count (RUN).
REQ-010 cmd_inputs_1  input  32  write data (writes) or initial accumulator (RUN).
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a clk edge.
REQ-013 rsp_outputs_0  output  32  response data.

Function
REQ-014 Opcodes SHALL be: 0 WR_INPUT, 1 WR_FILTER, 2 RUN, 3 RD_ACC; opcodes 4-7 SHALL behave as RD_ACC.
REQ-015 The FSM SHALL have states IDLE, RUN, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-016 WR_INPUT/WR_FILTER SHALL store cmd_inputs_1 at index cmd_inputs_0[ADDR_W-1:0] of the input/filter buffer, upper address bits ignored, then go to RESP with rsp_outputs_0 = 0.
REQ-017 RD_ACC SHALL go to RESP with rsp_outputs_0 = current accumulator register; the accumulator SHALL be unchanged.
REQ-018 RUN SHALL load acc <= cmd_inputs_1, idx <= 0, remaining <= min(cmd_inputs_0, DEPTH); if remaining is 0, go directly to RESP, else to RUN.
REQ-019 In RUN, each cycle SHALL process word idx: for lanes b=0..3, prod_b = (signed input byte b + 128) * signed filter byte b (17-bit signed product, no saturation); acc <= acc + (mode ? prod_0 : prod_0+prod_1+prod_2+prod_3), sign-extended, wrapping modulo 2^32.
REQ-020 RUN SHALL process exactly one word per cycle with idx incrementing; after the last word the FSM SHALL enter RESP with rsp_outputs_0 = final acc.
REQ-021 Latency: RUN with count N accepted at edge k SHALL raise rsp_valid after edge k+N+1 (N=0: after edge k+1); writes/RD_ACC after edge k+1.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_outputs_0 SHALL stay stable until rsp_ready; on handshake the FSM SHALL return to IDLE (cmd_ready 1 the following cycle, no back-to-back accept in the handshake cycle).
REQ-023 The filter/input buffers SHALL be written only by WR_* commands; their contents SHALL persist across RUNs.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect; cmd_* SHALL be ignored when cmd_ready is 0.

Reset
REQ-025 On reset assertion, state SHALL become IDLE, acc 0, idx 0, remaining 0, rsp_valid 0, rsp_outputs_0 0, cmd_ready 1 after release.
REQ-026 Reset during RUN or RESP SHALL abort the operation with no response; buffer contents need not be reset and SHALL NOT be relied upon after reset until rewritten.

Verification
REQ-027 WR_INPUT addr 0 data 0x00000000, WR_FILTER addr 0 data 0x01010101, RUN count 1 acc 0 -> rsp 512, rsp_valid 2 cycles after RUN accept.
REQ-028 Same buffers, RUN count 1, function_id[3]=1, acc 10 -> rsp 138.
REQ-029 Input 0x80808080, filter 0x7F7F7F7F at addr 1, RUN count 2 from acc 0 -> rsp 512 (word 1 contributes 0).
REQ-030 RUN count 0 acc 0xFFFFFFFF -> rsp 0xFFFFFFFF after 1 cycle; RUN count 1000 -> exactly DEPTH processing cycles; acc 0xFFFFFFFF plus 512 -> 0x000001FF.
REQ-031 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rsp_outputs_0 stable, cmd_ready 0, second cmd_valid ignored; then RD_ACC returns same value.
REQ-032 Assert reset mid-RUN -> rsp_valid 0 immediately, no response emitted, RD_ACC after release returns 0.
